// File: rtl/reg_bridge_pkg.sv
// Shared types and constants for the MCU-facing register bridge.
// Frame layout: opcode byte {rw, 3'b000, addr[3:0]} followed, for writes,
// by two bytes {4'bxxxx, data[11:0]}.
package reg_bridge_pkg;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam int WR_FRAME_BITS  = 24;
  localparam int RD_OPCODE_BITS = 8;

  typedef struct packed {
    logic [3:0]  addr;
    logic [11:0] data;
  } reg_write_t;

  // Emit FSM encoding; the live state is visible as reg_bridge.emit_state.
  typedef enum logic [1:0] {
    EMIT_IDLE  = 2'd0,
    EMIT_SETUP = 2'd1,
    EMIT_HOLD  = 2'd2
  } emit_state_t;

endpackage

// File: rtl/reg_wr_fifo.sv
// Small synchronous FIFO of decoded register writes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only if a pop happens in the same cycle.
// Read data is first-word fall-through (valid whenever empty is low).
// DEPTH must be a power of 2 and at least 2.
module reg_wr_fifo
  import reg_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  reg_write_t push_data,
  input  logic       pop,
  output reg_write_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  reg_write_t  mem [DEPTH];
  logic        pop_ok;
  logic        push_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update: advance on accepted push / pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/reg_bridge.sv
// SPI target (mode 0) that turns 24-bit write frames into a held,
// toggle-flagged register-write stream for the mapper mux, with optional
// status readback.
// Optional feature: define REG_BRIDGE_READBACK_EN to build the 32-bit
// status snapshot/shift path; otherwise read opcodes are ignored and
// spi_miso is tied low.
module reg_bridge
  import reg_bridge_pkg::*;
#(
  parameter int HOLD_CYCLES = 256,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [31:0] status_reg,
  output logic [11:0] wr_reg,
  output logic [3:0]  wr_reg_addr,
  output logic        wr_reg_changed,
  output logic        fifo_overflow
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [5:0]    BIT_MAX   = 6'd63;
  localparam logic [5:0]    WR_LAST   = 6'(WR_FRAME_BITS - 1);
  localparam logic [5:0]    OP_LAST   = 6'(RD_OPCODE_BITS - 1);

  // ---------------- input conditioning ----------------
  logic [1:0] sck_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sck_d;
  logic       cs_d;

  // Two-stage synchronizers plus one edge-history stage for SCK and CS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_d     <= sck_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  logic sck_rise;
  logic cs_fall;
  logic cs_active;

  assign sck_rise  = sck_sync[1] && !sck_d;
  assign cs_fall   = cs_d && !cs_sync[1];
  assign cs_active = !cs_sync[1];

  // ---------------- frame shifter ----------------
  logic [5:0]               bit_cnt;
  logic [WR_FRAME_BITS-2:0] shreg;
  logic [WR_FRAME_BITS-1:0] frame_next;
  logic                     bit_take;

  assign bit_take   = cs_active && !cs_fall && sck_rise;
  assign frame_next = {shreg, mosi_sync[1]};

  // Shift MOSI on each SCK rise inside a frame; CS falling restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (cs_fall) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (bit_take) begin
      shreg <= frame_next[WR_FRAME_BITS-2:0];
      if (bit_cnt != BIT_MAX) bit_cnt <= bit_cnt + 6'd1;
    end
  end

  // The 24th rise completes a write frame; opcode is then in the top byte.
  logic       fifo_push;
  reg_write_t fifo_wdata;

  assign fifo_push        = bit_take && (bit_cnt == WR_LAST) && (frame_next[23] == OP_WRITE);
  assign fifo_wdata.addr  = frame_next[19:16];
  assign fifo_wdata.data  = frame_next[11:0];

  logic unused_frame_bits;
  assign unused_frame_bits = ^{frame_next[22:20], frame_next[15:12]};

  // ---------------- write FIFO ----------------
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  reg_write_t fifo_rdata;

  reg_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky drop flag: a push into a full FIFO with no simultaneous pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   fifo_overflow <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) fifo_overflow <= 1'b1;
  end

  // ---------------- emit FSM ----------------
  emit_state_t emit_state;
  emit_state_t emit_state_d;
  logic [HW-1:0] hold_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) emit_state <= EMIT_IDLE;
    else        emit_state <= emit_state_d;
  end

  // Next state and FIFO pop: IDLE pops, SETUP toggles, HOLD counts down.
  always_comb begin
    emit_state_d = emit_state;
    fifo_pop     = 1'b0;
    unique case (emit_state)
      EMIT_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          emit_state_d = EMIT_SETUP;
        end
      end
      EMIT_SETUP: emit_state_d = EMIT_HOLD;
      EMIT_HOLD: begin
        if (hold_cnt == '0) emit_state_d = EMIT_IDLE;
      end
      default: emit_state_d = EMIT_IDLE;
    endcase
  end

  // Output pair loads only on IDLE->SETUP; the toggle follows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg         <= '0;
      wr_reg_addr    <= '0;
      wr_reg_changed <= 1'b0;
      hold_cnt       <= '0;
    end else begin
      if (fifo_pop) begin
        wr_reg_addr <= fifo_rdata.addr;
        wr_reg      <= fifo_rdata.data;
      end
      if (emit_state == EMIT_SETUP) begin
        wr_reg_changed <= !wr_reg_changed;
        hold_cnt       <= HOLD_LOAD;
      end else if ((emit_state == EMIT_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - HOLD_ONE;
      end
    end
  end

  // ---------------- status readback ----------------
`ifdef REG_BRIDGE_READBACK_EN
  logic        sck_fall;
  logic        rd_start;
  logic        rd_armed;
  logic [31:0] rd_shift;
  logic        miso_q;

  assign sck_fall = !sck_sync[1] && sck_d;
  assign rd_start = bit_take && (bit_cnt == OP_LAST) && (frame_next[7] == OP_READ);
  assign spi_miso = miso_q;

  // Snapshot on the 8th rise, then shift one bit out per SCK fall; the
  // zero fill makes MISO read 0 once all 32 bits are gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_armed <= 1'b0;
      rd_shift <= '0;
      miso_q   <= 1'b0;
    end else if (!cs_active || cs_fall) begin
      rd_armed <= 1'b0;
      rd_shift <= '0;
      miso_q   <= 1'b0;
    end else if (rd_start) begin
      rd_armed <= 1'b1;
      rd_shift <= status_reg;
    end else if (rd_armed && sck_fall) begin
      miso_q   <= rd_shift[31];
      rd_shift <= {rd_shift[30:0], 1'b0};
    end
  end
`else
  logic unused_readback;
  assign unused_readback = ^{status_reg, OP_LAST};
  assign spi_miso        = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bridge.sv
// Directed bench for reg_bridge: SPI driver tasks, a scoreboard queue of
// expected {addr, data} pairs filled when frames are issued, and a monitor
// that pops and compares on every wr_reg_changed toggle.
module tb_reg_bridge;

  localparam int HOLD  = 1600;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [31:0] status_reg;
  logic [11:0] wr_reg;
  logic [3:0]  wr_reg_addr;
  logic        wr_reg_changed;
  logic        fifo_overflow;

  reg_bridge #(
    .HOLD_CYCLES (HOLD),
    .FIFO_DEPTH  (DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_sck        (spi_sck),
    .spi_cs_n       (spi_cs_n),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .status_reg     (status_reg),
    .wr_reg         (wr_reg),
    .wr_reg_addr    (wr_reg_addr),
    .wr_reg_changed (wr_reg_changed),
    .fifo_overflow  (fifo_overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int          tog_t[$];
  int          tog_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          last_rise_cyc = 0;
  logic        prev_chg = 1'b0;
  logic [31:0] status_after = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each toggle must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_chg = 1'b0;
    end else if (wr_reg_changed !== prev_chg) begin
      prev_chg = wr_reg_changed;
      tog_cnt++;
      tog_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_toggle: got {addr,data}=0x%0h, expected no toggle", {wr_reg_addr, wr_reg});
      end else begin
        check("wr_pair", {wr_reg_addr, wr_reg}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Mode-0 frame, MSB first, SCK = clk/8. MISO is sampled just before each rise.
  task automatic spi_xfer(input logic [63:0] bits, input int nbits, output logic [63:0] miso_bits);
    miso_bits = '0;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = bits[nbits-1-i];
      repeat (4) @(negedge clk);
      miso_bits = {miso_bits[62:0], spi_miso};
      spi_sck = 1'b1;
      if (i == 23) last_rise_cyc = cyc;
      if (i == 10) status_reg = status_after;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_write(input logic [3:0] a, input logic [11:0] d, input logic [2:0] resv, input bit expect_it);
    logic [63:0] dummy;
    if (expect_it) exp_q.push_back({a, d});
    spi_xfer({40'h0, 1'b0, resv, a, 4'hF & {4{resv[0]}}, d}, 24, dummy);
  endtask

  task automatic wait_toggles(input int target, input int budget, input string name);
    int n = 0;
    while (tog_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(tog_cnt >= target), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] mbits;
    int          t0;

    rst_n      = 1'b0;
    spi_sck    = 1'b0;
    spi_cs_n   = 1'b1;
    spi_mosi   = 1'b0;
    status_reg = 32'h0;
    repeat (4) @(negedge clk);

    // Reset values.
    check("rst_wr_reg", wr_reg, 12'h000);
    check("rst_wr_reg_addr", wr_reg_addr, 4'h0);
    check("rst_wr_reg_changed", wr_reg_changed, 1'b0);
    check("rst_spi_miso", spi_miso, 1'b0);
    check("rst_fifo_overflow", fifo_overflow, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single write 0x00 0x0A 0x45: toggle 3 cycles of edge detect + 2.
    send_write(4'h0, 12'hA45, 3'b000, 1'b1);
    wait_toggles(1, 100, "single_toggle_timeout");
    check("single_latency", tog_t[0] - last_rise_cyc, 5);
    check("single_changed", wr_reg_changed, 1'b1);
    check("single_no_overflow", fifo_overflow, 1'b0);
    repeat (HOLD + 20) @(negedge clk);

    // Burst of 6 during the first hold: first drains at once, 4 buffer, 6th drops.
    for (int i = 1; i <= 6; i++) begin
      send_write(4'(i), {3{4'(i)}}, 3'(i), i <= 5);
    end
    wait_toggles(6, 5 * (HOLD + 2) + 200, "burst_toggle_timeout");
    repeat (HOLD + 50) @(negedge clk);
    check("burst_toggle_count", tog_cnt, 6);
    check("burst_overflow", fifo_overflow, 1'b1);
    for (int i = 1; i < 5; i++) begin
      check("burst_spacing", tog_t[i+1] - tog_t[i], HOLD + 2);
    end

    // Aborted frame after 16 bits, then two complete frames.
    spi_xfer({40'h0, 8'h07, 8'h0B, 8'hCC}, 16, mbits);
    repeat (50) @(negedge clk);
    check("abort_no_toggle", tog_cnt, 6);
    send_write(4'h9, 12'h3C3, 3'b000, 1'b1);
    send_write(4'hF, 12'hFFF, 3'b111, 1'b1);
    wait_toggles(8, 2 * (HOLD + 2) + 200, "abort_followup_timeout");
    repeat (HOLD + 20) @(negedge clk);

    // Readback: opcode 0x81, 44 SCKs; status changes after the snapshot.
    status_reg   = 32'h0000_01A5;
    status_after = 32'hFFFF_FFFF;
    spi_xfer({20'h0, 8'h81, 36'h0}, 44, mbits);
`ifdef REG_BRIDGE_READBACK_EN
    check("readback_bits", mbits[43:0], {8'h00, 32'h0000_01A5, 4'h0});
`else
    check("readback_bits", mbits[43:0], 44'h0);
`endif
    repeat (20) @(negedge clk);
    check("readback_no_toggle", tog_cnt, 8);
    check("readback_miso_idle", spi_miso, 1'b0);

    // Reset during hold with two entries queued.
    send_write(4'h2, 12'h5A5, 3'b000, 1'b1);
    wait_toggles(9, 100, "pre_reset_toggle_timeout");
    t0 = cyc;
    send_write(4'h3, 12'h123, 3'b000, 1'b0);
    send_write(4'h4, 12'h456, 3'b000, 1'b0);
    check("reset_still_holding", 64'((cyc - t0) < HOLD), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_rst_wr_reg", wr_reg, 12'h000);
    check("hold_rst_wr_reg_addr", wr_reg_addr, 4'h0);
    check("hold_rst_wr_reg_changed", wr_reg_changed, 1'b0);
    check("hold_rst_spi_miso", spi_miso, 1'b0);
    check("hold_rst_fifo_overflow", fifo_overflow, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * HOLD + 50) @(negedge clk);
    check("post_reset_no_toggle", tog_cnt, 9);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog in case a task stalls.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
